// File: rtl/backbone_pkg.sv
// Shared datapath types for the backbone layers.
package backbone_pkg;

    localparam int unsigned DATA_W = 16;

    typedef logic [DATA_W-1:0] data_t;

    // One output beat of a feature-map stream, data plus end-of-row/channel/frame markers.
    typedef struct packed {
        data_t data;
        logic  last_row;
        logic  last_ch;
        logic  last;
    } fmap_beat_t;

endpackage

// File: rtl/fmap_stream_reader_pkg.sv
// Local types and helpers for the feature-map stream reader.
package fmap_stream_reader_pkg;

    // Number of marker bits stored beside each data word.
    localparam int unsigned FLAG_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } fsm_state_t;

    // Counter width for a modulo-n counter, never less than one bit.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fmap_stream_reader_if.sv
// Control, buffer-read and output-stream signals of the feature-map reader.
interface fmap_stream_reader_if #(
    parameter int unsigned ADDR_W = 18,
    parameter int unsigned DATA_W = backbone_pkg::DATA_W
);
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic              busy;
    logic              done;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rd_data;
    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_data;
    logic              m_last_row;
    logic              m_last_ch;
    logic              m_last;

    modport master (
        input  start, base_addr, mem_rd_data, m_ready,
        output busy, done, mem_rd_en, mem_addr,
        output m_valid, m_data, m_last_row, m_last_ch, m_last
    );

    modport slave (
        output start, base_addr, mem_rd_data, m_ready,
        input  busy, done, mem_rd_en, mem_addr,
        input  m_valid, m_data, m_last_row, m_last_ch, m_last
    );
endinterface

// File: rtl/fmap_skid_fifo.sv
// Two-entry FIFO that absorbs the one-cycle buffer read latency.
module fmap_skid_fifo #(
    parameter int unsigned WIDTH = backbone_pkg::DATA_W + fmap_stream_reader_pkg::FLAG_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic [1:0]       count,
    output logic             empty
);
    logic [WIDTH-1:0] r_mem [2];
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [1:0]       r_count;
    logic             w_push;
    logic             w_pop;

    assign w_pop  = pop && (r_count != 2'd0);
    assign w_push = push && ((r_count != 2'd2) || w_pop);
    assign dout   = r_mem[r_rd_ptr];
    assign count  = r_count;
    assign empty  = (r_count == 2'd0);

    // Storage, pointers and occupancy; simultaneous push/pop keeps the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= din;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/fmap_stream_reader.sv
// Streams a CxHxW feature map from the on-chip buffer as valid/ready beats in CHW order.
module fmap_stream_reader
    import fmap_stream_reader_pkg::*;
#(
    parameter int unsigned C      = 64,
    parameter int unsigned H      = 56,
    parameter int unsigned W      = 56,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 18
) (
    input  logic                 clk,
    input  logic                 rst_n,
    fmap_stream_reader_if.master bus
);
    localparam int unsigned N_WORDS = C * H * W;
    localparam int unsigned CW      = cnt_w(C);
    localparam int unsigned HW      = cnt_w(H);
    localparam int unsigned WW      = cnt_w(W);
    localparam int unsigned BEAT_W  = DATA_W + FLAG_W;

    fsm_state_t          r_state;
    logic                r_busy;
    logic                r_done;
    logic [ADDR_W-1:0]   r_base;
    logic [ADDR_W-1:0]   r_issued;
    logic [ADDR_W-1:0]   r_last_addr;
    logic [CW-1:0]       r_c;
    logic [HW-1:0]       r_h;
    logic [WW-1:0]       r_w;
    logic                r_inflight;
    logic [FLAG_W-1:0]   r_tag;

    logic [1:0]          w_fifo_count;
    logic                w_fifo_empty;
    logic [BEAT_W-1:0]   w_fifo_din;
    logic [BEAT_W-1:0]   w_fifo_dout;
    logic                w_pop;
    logic [2:0]          w_occupancy;
    logic [2:0]          w_limit;
    logic                w_rd_en;
    logic [ADDR_W-1:0]   w_rd_addr;
    logic                w_w_end;
    logic                w_h_end;
    logic                w_c_end;
    logic                w_start_acc;

    // Issue a read only while the FIFO plus the in-flight word can still hold it.
    assign w_pop       = !w_fifo_empty && bus.m_ready;
    assign w_occupancy = 3'(w_fifo_count) + 3'(r_inflight);
    assign w_limit     = 3'd2 + 3'(w_pop);
    assign w_rd_en     = (r_state == ST_RUN) && (w_occupancy < w_limit);
    assign w_rd_addr   = r_base + r_issued;
    assign w_start_acc = (r_state == ST_IDLE) && bus.start;

    assign w_w_end = (r_w == WW'(W - 1));
    assign w_h_end = (r_h == HW'(H - 1));
    assign w_c_end = (r_c == CW'(C - 1));

    assign w_fifo_din = {r_tag, bus.mem_rd_data};

    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.mem_rd_en  = w_rd_en;
    assign bus.mem_addr   = w_rd_en ? w_rd_addr : r_last_addr;
    assign bus.m_valid    = !w_fifo_empty;
    assign bus.m_data     = w_fifo_dout[DATA_W-1:0];
    assign bus.m_last_row = w_fifo_dout[DATA_W];
    assign bus.m_last_ch  = w_fifo_dout[DATA_W+1];
    assign bus.m_last     = w_fifo_dout[DATA_W+2];

    // Frame sequencing: IDLE -> RUN -> DRAIN -> DONE, with busy/done registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_base  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_state <= ST_RUN;
                        r_busy  <= 1'b1;
                        r_base  <= bus.base_addr;
                    end
                end
                ST_RUN: begin
                    if (w_rd_en && (r_issued == ADDR_W'(N_WORDS - 1))) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (w_pop && w_fifo_dout[DATA_W+2]) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Read counter and (c,h,w) position of the next word to be issued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_issued    <= '0;
            r_last_addr <= '0;
            r_c         <= '0;
            r_h         <= '0;
            r_w         <= '0;
        end else if (w_start_acc) begin
            r_issued <= '0;
            r_c      <= '0;
            r_h      <= '0;
            r_w      <= '0;
        end else if (w_rd_en) begin
            r_issued    <= r_issued + ADDR_W'(1);
            r_last_addr <= w_rd_addr;
            if (w_w_end) begin
                r_w <= '0;
                if (w_h_end) begin
                    r_h <= '0;
                    r_c <= w_c_end ? '0 : r_c + CW'(1);
                end else begin
                    r_h <= r_h + HW'(1);
                end
            end else begin
                r_w <= r_w + WW'(1);
            end
        end
    end

    // Track the outstanding read and carry its end markers to the FIFO write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inflight <= 1'b0;
            r_tag      <= '0;
        end else begin
            r_inflight <= w_rd_en;
            if (w_rd_en) begin
                r_tag <= {w_c_end && w_h_end && w_w_end, w_h_end && w_w_end, w_w_end};
            end
        end
    end

    fmap_skid_fifo #(
        .WIDTH (BEAT_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (r_inflight),
        .din   (w_fifo_din),
        .pop   (w_pop),
        .dout  (w_fifo_dout),
        .count (w_fifo_count),
        .empty (w_fifo_empty)
    );

endmodule
